// File: rtl/ksm_pvic.sv
// Parametrised vectored interrupt controller: masks and arbitrates N level requests,
// answers the CPU vector-fetch cycle and exposes MASK/PEND through a small register port.
module ksm_pvic #(
    parameter int N      = 3,
    parameter int ROTATE = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    output logic              wb_irq_o,
    output logic [15:0]       wb_dat_o,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    input  logic              wb_una_i,
    input  logic [15:0]       rsel,
    input  logic [16*N-1:0]   ivec,
    input  logic [N-1:0]      ireq,
    output logic [N-1:0]      iack,
    input  logic              reg_stb_i,
    input  logic              reg_adr_i,
    input  logic              reg_we_i,
    input  logic [1:0]        reg_sel_i,
    input  logic [15:0]       reg_dat_i,
    output logic [15:0]       reg_dat_o,
    output logic              reg_ack_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state_r;
    logic [N-1:0] mask_r;
    logic [3:0]   ptr_r;
    logic         reg_seen_r;

    logic [N-1:0] pend_s;
    logic [N-1:0] gnt_s;
    logic [N-1:0] mask_nxt_s;
    logic [15:0]  reg_rd_s;
    logic [3:0]   win_s;
    logic         found_s;
    int           cand_s;
    logic         fetch_s;
    logic         reg_acc_s;

    assign pend_s    = ireq & ~mask_r;
    assign fetch_s   = (state_r == ST_IDLE) && wb_stb_i;
    assign reg_acc_s = reg_stb_i && !reg_seen_r;

    // Arbitration: fixed scans from N-1 down; rotating scans from ptr-1 down with wrap.
    always_comb begin
        found_s = 1'b0;
        win_s   = 4'd0;
        cand_s  = 0;
        for (int i = 0; i < N; i++) begin
            if (ROTATE != 0) begin
                cand_s = (int'(ptr_r) + 2 * N - 1 - i) % N;
            end else begin
                cand_s = N - 1 - i;
            end
            if (!found_s && pend_s[cand_s]) begin
                found_s = 1'b1;
                win_s   = 4'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant for the winner and byte-lane merged mask write value.
    always_comb begin
        gnt_s      = '0;
        mask_nxt_s = mask_r;
        for (int j = 0; j < N; j++) begin
            gnt_s[j] = found_s && (4'(j) == win_s);
            if (((j < 8) && reg_sel_i[0]) || ((j >= 8) && reg_sel_i[1])) begin
                mask_nxt_s[j] = reg_dat_i[j];
            end else begin
                mask_nxt_s[j] = mask_r[j];
            end
        end
    end

    // Register read data, zero-extended above the channel count.
    always_comb begin
        reg_rd_s = 16'h0000;
        if (reg_adr_i) begin
            reg_rd_s[N-1:0] = pend_s;
        end else begin
            reg_rd_s[N-1:0] = mask_r;
        end
    end

    // Vector-fetch FSM; winner, vector and grant are frozen on the IDLE->ACK edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r  <= ST_IDLE;
            ptr_r    <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 16'h0000;
            iack     <= '0;
            wb_irq_o <= 1'b0;
        end else begin
            wb_irq_o <= (state_r == ST_IDLE) && !wb_stb_i && (|pend_s);
            case (state_r)
                ST_IDLE: begin
                    if (wb_stb_i) begin
                        state_r  <= ST_ACK;
                        wb_ack_o <= 1'b1;
                        if (wb_una_i) begin
                            wb_dat_o <= rsel;
                        end else if (found_s) begin
                            wb_dat_o <= ivec[int'(win_s)*16 +: 16];
                            iack     <= gnt_s;
                            ptr_r    <= win_s;
                        end else begin
                            wb_dat_o <= 16'h0000;
                        end
                    end
                end
                ST_ACK: begin
                    state_r  <= ST_DONE;
                    wb_ack_o <= 1'b0;
                    iack     <= '0;
                end
                ST_DONE: begin
                    if (!wb_stb_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    wb_ack_o <= 1'b0;
                    iack     <= '0;
                end
            endcase
        end
    end

    // Register port: one ack per strobe; the strobe must drop before the next access.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            mask_r     <= '0;
            reg_seen_r <= 1'b0;
            reg_ack_o  <= 1'b0;
            reg_dat_o  <= 16'h0000;
        end else begin
            reg_seen_r <= reg_stb_i;
            reg_ack_o  <= reg_acc_s;
            if (reg_acc_s) begin
                reg_dat_o <= reg_rd_s;
                if (reg_we_i && !reg_adr_i) begin
                    mask_r <= mask_nxt_s;
                end
            end
        end
    end

endmodule
